locked_register_bank: RTL and testbench

- Parametrised successor to the single sticky-lock register: a bank of NUM_REGS registers of DATA_W bits, each with its own sticky write lock.
- Adds a key-authenticated debug-override session (FSM with brute-force lockout). Locked registers are writable only through an authenticated trusted debug session, never by debug_mode/trusted alone.
- Sits between the configuration bus and security-relevant control registers.

---
 rtl/locked_register_bank.sv | 166 ++++++++++++++++
 tb/tb_locked_register_bank.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/locked_register_bank.sv
// Bank of NUM_REGS sticky-lockable registers with a key-authenticated debug-override session.
// Latency: writes land at the next clock edge; rd_data and write_err are registered (1 cycle).
// Backpressure: none; rejected writes are dropped and flagged by a one-cycle write_err pulse.
module locked_register_bank #(
    parameter int                NUM_REGS       = 4,
    parameter int                DATA_W         = 16,
    parameter int                ADDR_W         = 2,
    parameter logic [DATA_W-1:0] KEY0           = 16'hA5C3,
    parameter logic [DATA_W-1:0] KEY1           = 16'h3C5A,
    parameter int                LOCKOUT_CYCLES = 64
) (
    input  logic                Clk,
    input  logic                reset,
    input  logic                write,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   Data_in,
    input  logic                lock,
    input  logic                lock_all,
    input  logic                trusted,
    input  logic                debug_mode,
    input  logic                key_valid,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic [NUM_REGS-1:0] lock_status,
    output logic                dbg_unlocked,
    output logic                write_err
);

    localparam int CNT_W = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_KEY1_WAIT,
        ST_UNLOCKED,
        ST_LOCKOUT
    } dbg_state_t;

    dbg_state_t        state, state_nxt;
    logic [CNT_W-1:0]  lockout_cnt, lockout_cnt_nxt;

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic [NUM_REGS-1:0] addr_hit;
    logic [NUM_REGS-1:0] rd_hit;
    logic                addr_ok;
    logic                tgt_locked;
    logic                dbg_priv;
    logic                wr_accept;
    logic                wr_reject;
    logic                qualified;
    logic [DATA_W-1:0]   rd_data_nxt;

    // Decode write/read addresses into one-hot hit vectors; out-of-range addresses hit nothing.
    always_comb begin
        addr_hit    = '0;
        rd_hit      = '0;
        rd_data_nxt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            addr_hit[i] = (addr == ADDR_W'(i));
            rd_hit[i]   = (rd_addr == ADDR_W'(i));
            if (rd_hit[i]) begin
                rd_data_nxt = regs[i];
            end
        end
    end

    assign addr_ok   = |addr_hit;
    assign qualified = trusted & debug_mode;
    // A lock arriving in the same cycle as the write already counts against it.
    assign tgt_locked = lock | lock_all | (|(addr_hit & lock_status));
    assign dbg_priv   = qualified & dbg_unlocked;
    // Key cycles never write; out-of-range addresses never write.
    assign wr_accept  = write & ~key_valid & addr_ok & (~tgt_locked | dbg_priv);
    assign wr_reject  = write & ~wr_accept;

    // Debug-session next state: two-word key, any bad word sends us to a fixed-length lockout.
    always_comb begin
        state_nxt       = state;
        lockout_cnt_nxt = lockout_cnt;
        case (state)
            ST_IDLE: begin
                if (key_valid && qualified) begin
                    if (Data_in == KEY0) begin
                        state_nxt = ST_KEY1_WAIT;
                    end else begin
                        state_nxt       = ST_LOCKOUT;
                        lockout_cnt_nxt = CNT_LOAD;
                    end
                end
            end
            ST_KEY1_WAIT: begin
                if (!qualified) begin
                    state_nxt = ST_IDLE;
                end else if (key_valid) begin
                    if (Data_in == KEY1) begin
                        state_nxt = ST_UNLOCKED;
                    end else begin
                        state_nxt       = ST_LOCKOUT;
                        lockout_cnt_nxt = CNT_LOAD;
                    end
                end
            end
            ST_UNLOCKED: begin
                if (!qualified) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                // Runs to completion regardless of qualifiers or further key attempts.
                if (lockout_cnt == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    lockout_cnt_nxt = lockout_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Debug-session state register; dbg_unlocked is a flop mirroring the UNLOCKED state.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            lockout_cnt  <= '0;
            dbg_unlocked <= 1'b0;
        end else begin
            state        <= state_nxt;
            lockout_cnt  <= lockout_cnt_nxt;
            dbg_unlocked <= (state_nxt == ST_UNLOCKED);
        end
    end

    // Register storage and sticky lock bits; locks only ever set, reset is the sole clear.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            lock_status <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_accept && addr_hit[i]) begin
                    regs[i] <= Data_in;
                end
                if (lock_all || (lock && addr_hit[i])) begin
                    lock_status[i] <= 1'b1;
                end
            end
        end
    end

    // Registered read port and rejected-write pulse.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            rd_data   <= '0;
            write_err <= 1'b0;
        end else begin
            rd_data   <= rd_data_nxt;
            write_err <= wr_reject;
        end
    end

endmodule

// File: tb/tb_locked_register_bank.sv
// Directed bench for locked_register_bank: locking, debug-key session, lockout timing, reset.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
// All expected values are hand-derived constants.
module tb_locked_register_bank;

    logic        Clk = 1'b0;
    logic        reset;
    logic        write;
    logic [1:0]  addr;
    logic [15:0] Data_in;
    logic        lock;
    logic        lock_all;
    logic        trusted;
    logic        debug_mode;
    logic        key_valid;
    logic [1:0]  rd_addr;
    logic [15:0] rd_data;
    logic [3:0]  lock_status;
    logic        dbg_unlocked;
    logic        write_err;

    int n_tests = 0;
    int n_fail  = 0;

    locked_register_bank dut (
        .Clk          (Clk),
        .reset        (reset),
        .write        (write),
        .addr         (addr),
        .Data_in      (Data_in),
        .lock         (lock),
        .lock_all     (lock_all),
        .trusted      (trusted),
        .debug_mode   (debug_mode),
        .key_valid    (key_valid),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .lock_status  (lock_status),
        .dbg_unlocked (dbg_unlocked),
        .write_err    (write_err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [15:0] d);
        write   = 1'b1;
        addr    = a;
        Data_in = d;
        tick();
        write   = 1'b0;
    endtask

    task automatic do_key(input logic [15:0] k);
        key_valid = 1'b1;
        Data_in   = k;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [15:0] exp);
        rd_addr = a;
        tick();
        check(tag, rd_data, exp);
    endtask

    initial begin
        reset = 1'b1; write = 1'b0; addr = '0; Data_in = '0; lock = 1'b0; lock_all = 1'b0;
        trusted = 1'b0; debug_mode = 1'b0; key_valid = 1'b0; rd_addr = '0;
        tick();
        tick();
        check("rst_rd_data", rd_data, 16'h0);
        check("rst_lock_status", lock_status, 4'b0000);
        check("rst_dbg_unlocked", dbg_unlocked, 1'b0);
        check("rst_write_err", write_err, 1'b0);
        reset = 1'b0;
        tick();

        // Plain write, lock, then rejected overwrite.
        do_write(2'd1, 16'h1234);
        check("wr1_err", write_err, 1'b0);
        lock = 1'b1; addr = 2'd1;
        tick();
        lock = 1'b0;
        check("lock1_status", lock_status, 4'b0010);
        do_write(2'd1, 16'hFFFF);
        check("locked_wr_err", write_err, 1'b1);
        tick();
        check("err_single_pulse", write_err, 1'b0);
        read_check("reg1_kept", 2'd1, 16'h1234);

        // Write colliding with key_valid on an unlocked register is dropped.
        write = 1'b1; key_valid = 1'b1; addr = 2'd0; Data_in = 16'h7777;
        tick();
        write = 1'b0; key_valid = 1'b0;
        check("key_wr_collide_err", write_err, 1'b1);
        read_check("reg0_untouched", 2'd0, 16'h0000);

        // Qualifiers alone grant nothing.
        trusted = 1'b1; debug_mode = 1'b1;
        do_write(2'd1, 16'hBEEF);
        check("noauth_wr_err", write_err, 1'b1);
        read_check("noauth_reg1", 2'd1, 16'h1234);

        // Authenticated session.
        do_key(16'hA5C3);
        check("key0_not_unlocked", dbg_unlocked, 1'b0);
        do_key(16'h3C5A);
        check("key1_unlocked", dbg_unlocked, 1'b1);
        do_write(2'd1, 16'hBEEF);
        check("auth_wr_err", write_err, 1'b0);
        read_check("auth_reg1", 2'd1, 16'hBEEF);
        trusted = 1'b0;
        tick();
        check("drop_trusted_dbg", dbg_unlocked, 1'b0);
        do_write(2'd1, 16'h1111);
        check("post_drop_wr_err", write_err, 1'b1);
        read_check("post_drop_reg1", 2'd1, 16'hBEEF);

        // Bad key -> 64-cycle lockout; edge of the window probed exactly.
        trusted = 1'b1;
        do_key(16'hA5C3);
        do_key(16'h0000);                 // lockout entered at this edge (E0)
        check("lockout_dbg", dbg_unlocked, 1'b0);
        do_key(16'hA5C3);                 // E1
        do_key(16'h3C5A);                 // E2
        check("lockout_keys_ignored", dbg_unlocked, 1'b0);
        for (int i = 0; i < 61; i++) tick(); // E3..E63
        do_key(16'hA5C3);                 // E64: last lockout cycle, ignored
        check("lockout_last_cycle", dbg_unlocked, 1'b0);
        do_key(16'hA5C3);                 // E65: IDLE accepts KEY0
        check("post_lockout_key0", dbg_unlocked, 1'b0);
        do_key(16'h3C5A);                 // E66
        check("post_lockout_unlock", dbg_unlocked, 1'b1);
        debug_mode = 1'b0;
        tick();
        check("drop_debug_dbg", dbg_unlocked, 1'b0);
        trusted = 1'b0;

        // Lock and write same register same cycle: lock wins.
        write = 1'b1; lock = 1'b1; addr = 2'd2; Data_in = 16'h00AA;
        tick();
        write = 1'b0; lock = 1'b0;
        check("lockwr_err", write_err, 1'b1);
        check("lockwr_status", lock_status, 4'b0110);
        read_check("lockwr_reg2", 2'd2, 16'h0000);
        lock_all = 1'b1;
        tick();
        lock_all = 1'b0;
        check("lock_all_status", lock_status, 4'b1111);
        for (int a = 0; a < 4; a++) begin
            do_write(2'(a), 16'h5555);
            check($sformatf("lock_all_wr_err%0d", a), write_err, 1'b1);
        end
        read_check("la_reg0", 2'd0, 16'h0000);
        read_check("la_reg1", 2'd1, 16'hBEEF);
        read_check("la_reg2", 2'd2, 16'h0000);
        read_check("la_reg3", 2'd3, 16'h0000);

        // Reset in the middle of an unlocked session.
        trusted = 1'b1; debug_mode = 1'b1;
        do_key(16'hA5C3);
        do_key(16'h3C5A);
        check("resess_unlocked", dbg_unlocked, 1'b1);
        do_write(2'd3, 16'h9999);
        check("resess_wr_err", write_err, 1'b0);
        read_check("resess_reg3", 2'd3, 16'h9999);
        #2 reset = 1'b1;
        #1;
        check("async_rst_dbg", dbg_unlocked, 1'b0);
        check("async_rst_locks", lock_status, 4'b0000);
        check("async_rst_rd", rd_data, 16'h0000);
        #1 reset = 1'b0;
        trusted = 1'b0; debug_mode = 1'b0;
        tick();
        do_write(2'd3, 16'h4321);
        check("post_rst_wr_err", write_err, 1'b0);
        read_check("post_rst_reg3", 2'd3, 16'h4321);
        read_check("post_rst_reg1", 2'd1, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
